// File: rtl/data_memory_bank.sv
// Byte-writable word memory that self-initialises dmem[i] = i after reset, then serves
// read-first accesses with one-cycle read latency. Optional even parity: DMEM_PARITY_EN.
module data_memory_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    WriteEn,
  input  logic                    ReadEn,
  input  logic [DATA_WIDTH/8-1:0] ByteEn,
  input  logic [ADDR_WIDTH-1:0]   Address,
  input  logic [DATA_WIDTH-1:0]   WriteData,
  output logic [DATA_WIDTH-1:0]   ReadData,
  output logic                    ReadValid,
  output logic                    Busy,
  output logic                    ParityErr
);

  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int NUM_BYTES = DATA_WIDTH / 8;

  typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;

  // state is kept as a plain named signal so checkers can bind to it directly.
  state_t                  state, stateNext;
  logic [ADDR_WIDTH-1:0]   initCount;
  logic [DATA_WIDTH-1:0]   dmem [DEPTH];
  logic [DATA_WIDTH-1:0]   mergedWord;
  logic [DATA_WIDTH-1:0]   initWord;
  logic                    writeFire;
  logic                    readFire;

  // ReadValid is a one-cycle pulse: it is high exactly in the cycle after an accepted
  // read edge, and ReadData is meaningful only while it is high (there is no ready/stall).
  always_comb begin
    stateNext = state;
    Busy      = (state == INIT);
    if (state == INIT && initCount == ADDR_WIDTH'(DEPTH - 1)) begin
      stateNext = READY;
    end
  end

  always_comb begin
    mergedWord = dmem[Address];
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (ByteEn[b]) begin
        mergedWord[8*b +: 8] = WriteData[8*b +: 8];
      end
    end
  end

  assign initWord  = DATA_WIDTH'(initCount);
  assign writeFire = (state == READY) && WriteEn && (|ByteEn);
  assign readFire  = (state == READY) && ReadEn;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      initCount <= '0;
    end else begin
      state <= stateNext;
      if (state == INIT) begin
        initCount <= initCount + 1'b1;
      end
    end
  end

  // The array has no reset; only the INIT sweep rewrites it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == INIT) begin
        dmem[initCount] <= initWord;
      end else if (writeFire) begin
        dmem[Address] <= mergedWord;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ReadData  <= '0;
      ReadValid <= 1'b0;
    end else begin
      ReadValid <= readFire;
      if (readFire) begin
        ReadData <= dmem[Address];
      end
    end
  end

`ifdef DMEM_PARITY_EN
  logic parityMem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == INIT) begin
        parityMem[initCount] <= ^initWord;
      end else if (writeFire) begin
        parityMem[Address] <= ^mergedWord;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ParityErr <= 1'b0;
    end else begin
      ParityErr <= readFire && ((^dmem[Address]) != parityMem[Address]);
    end
  end
`else
  assign ParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_bank.sv
// Directed bench for data_memory_bank: init timing, byte writes, read-first,
// reset restarts and the parity flag (DMEM_PARITY_EN when defined).
module tb_data_memory_bank;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          WriteEn;
  logic          ReadEn;
  logic [DW/8-1:0] ByteEn;
  logic [AW-1:0] Address;
  logic [DW-1:0] WriteData;
  logic [DW-1:0] ReadData;
  logic          ReadValid;
  logic          Busy;
  logic          ParityErr;

  int total = 0;
  int bad   = 0;
  int cycles;
  logic sawValid;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] expWord;

  data_memory_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .WriteEn(WriteEn), .ReadEn(ReadEn), .ByteEn(ByteEn),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
    .ReadValid(ReadValid), .Busy(Busy), .ParityErr(ParityErr)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    WriteEn = 1'b0; ReadEn = 1'b0; ByteEn = '0; Address = '0; WriteData = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] be);
    WriteEn = 1'b1; ByteEn = be; Address = a; WriteData = d;
    step();
    WriteEn = 1'b0; ByteEn = '0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    ReadEn = 1'b1; Address = a;
    step();
    ReadEn = 1'b0;
  endtask

  // Counts Busy cycles after reset release; optionally injects a write+read at init cycle 2.
  task automatic wait_init(input logic inject);
    cycles = 0;
    sawValid = 1'b0;
    while (Busy && cycles < 100) begin
      if (inject && cycles == 2) begin
        WriteEn = 1'b1; ReadEn = 1'b1; Address = 5'd31; WriteData = '1; ByteEn = '1;
      end else begin
        WriteEn = 1'b0; ReadEn = 1'b0; ByteEn = '0;
      end
      step();
      cycles++;
      if (Busy && ReadValid) sawValid = 1'b1;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    check("reset_readdata", ReadData, '0);
    check("reset_readvalid", DW'(ReadValid), '0);
    check("reset_parityerr", DW'(ParityErr), '0);
    check("reset_busy", DW'(Busy), 1);

    rst_n = 1'b1;
    wait_init(1'b0);
    check("init_busy_cycles", DW'(cycles), 32);

    do_read(5'd7);
    check("read7_data", ReadData, 32'h0000_0007);
    check("read7_valid", DW'(ReadValid), 1);
    check("read7_parity", DW'(ParityErr), 0);
    step();
    check("read7_valid_drop", DW'(ReadValid), 0);
    check("read7_data_hold", ReadData, 32'h0000_0007);

    do_write(5'd3, 32'hDEAD_BEEF, 4'b0101);
    check("write_no_valid", DW'(ReadValid), 0);
    do_read(5'd3);
    check("byteen_merge", ReadData, 32'h00AD_00EF);

    do_write(5'd4, 32'hFFFF_FFFF, 4'b0000);
    do_read(5'd4);
    check("byteen_zero", ReadData, 32'h0000_0004);

    WriteEn = 1'b1; ReadEn = 1'b1; ByteEn = 4'hF; Address = 5'd10; WriteData = 32'h1234_5678;
    step();
    idle_inputs();
    check("read_first_old", ReadData, 32'h0000_000A);
    check("read_first_valid", DW'(ReadValid), 1);
    do_read(5'd10);
    check("read_after_write", ReadData, 32'h1234_5678);

    do_read(5'd0);
    check("read_addr0", ReadData, 32'h0000_0000);
    do_read(5'd31);
    check("read_addr31", ReadData, 32'h0000_001F);

    // reset from READY, then again at init count 15
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) step();
    check("midinit_busy", DW'(Busy), 1);
    rst_n = 1'b0;
    step();
    check("midinit_reset_busy", DW'(Busy), 1);
    check("midinit_reset_valid", DW'(ReadValid), 0);
    rst_n = 1'b1;
    wait_init(1'b1);
    check("restart_busy_cycles", DW'(cycles), 32);
    check("no_valid_while_busy", DW'(sawValid), 0);

    for (int i = 0; i < 32; i++) exp_q.push_back(DW'(i));
    for (int i = 0; i < 32; i++) begin
      do_read(AW'(i));
      expWord = exp_q.pop_front();
      check($sformatf("sweep_addr%0d", i), ReadData, expWord);
    end

`ifdef DMEM_PARITY_EN
    dut.parityMem[5] = ~dut.parityMem[5];
    do_read(5'd5);
    check("parity_err_flag", DW'(ParityErr), 1);
    check("parity_err_valid", DW'(ReadValid), 1);
    step();
    check("parity_err_drop", DW'(ParityErr), 0);
`else
    do_read(5'd5);
    check("parity_tied_low", DW'(ParityErr), 0);
    check("parity_read_valid", DW'(ReadValid), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_bank.md
DATA_MEMORY_BANK -- requirements
Module: data_memory_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; legal values are multiples of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, word address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have port WriteEn, input, 1, write request.
REQ-006 SHALL have port ReadEn, input, 1, read request.
REQ-007 SHALL have port ByteEn, input, DATA_WIDTH/8, per-byte write strobe; bit k covers WriteData[8k+7:8k].
REQ-008 SHALL have port Address, input, ADDR_WIDTH, word address shared by read and write.
REQ-009 SHALL have port WriteData, input, DATA_WIDTH, write data.
REQ-010 SHALL have port ReadData, output, DATA_WIDTH, registered read data.
REQ-011 SHALL have port ReadValid, output, 1, one-cycle pulse qualifying ReadData.
REQ-012 SHALL have port Busy, output, 1, high while the initialisation sequence runs.
REQ-013 SHALL have port ParityErr, output, 1, parity mismatch on the current ReadValid beat.

Function
REQ-014 SHALL implement a two-state FSM: INIT, then READY.
REQ-015 INIT SHALL write dmem[i] = i (zero-extended), one word per cycle, i = 0 to DEPTH-1, with Busy = 1.
REQ-016 INIT SHALL move to READY in the cycle after writing word DEPTH-1, so Busy is high for exactly DEPTH cycles after reset release.
REQ-017 In INIT, WriteEn and ReadEn SHALL be ignored: no array update and ReadValid = 0.
REQ-018 In READY, a rising edge with WriteEn = 1 SHALL update only the bytes of dmem[Address] whose ByteEn bit is 1; other bytes keep their value.
REQ-019 WriteEn = 1 with ByteEn all zero SHALL leave the array unchanged.
REQ-020 In READY, ReadEn = 1 sampled at edge N SHALL load ReadData with dmem[Address] and assert ReadValid at edge N, both visible for the following cycle (1-cycle latency).
REQ-021 ReadValid SHALL deassert in any cycle without a sampled read.
REQ-022 ReadData SHALL hold its last value when ReadValid is low; it is never high-impedance.
REQ-023 A simultaneous read and write to the same address SHALL be read-first: ReadData returns the pre-write contents.
REQ-024 Address SHALL be used unmodified; no wrap or aliasing logic is required because every address value is in range.

Reset
REQ-025 rst_n = 0 at a rising edge SHALL set ReadData = 0, ReadValid = 0, ParityErr = 0, init counter = 0, and state = INIT (Busy = 1).
REQ-026 Reset asserted mid-INIT SHALL restart the sequence from word 0.
REQ-027 Reset asserted in READY SHALL re-initialise the whole array.
REQ-028 Array contents SHALL NOT be cleared combinationally; only the INIT sequence rewrites them.

Configuration
REQ-029 Macro DMEM_PARITY_EN defined: each word SHALL store one extra even-parity bit computed over the post-merge word on every write, including INIT writes.
REQ-030 With DMEM_PARITY_EN, each read SHALL recompute parity, and ParityErr SHALL equal (mismatch AND ReadValid).
REQ-031 Macro DMEM_PARITY_EN undefined: no parity storage SHALL be built and ParityErr SHALL be tied to 0; the port list is unchanged.

Verification
REQ-032 Release reset -> Busy high for exactly 32 cycles; then read addr 7 -> next cycle ReadData = 0x00000007 and ReadValid = 1 for one cycle.
REQ-033 Write 0xDEADBEEF with ByteEn = 4'b0101 to addr 3, then read addr 3 -> ReadData = 0x00AD00EF.
REQ-034 Same cycle: write 0x12345678 (ByteEn = 4'hF) and read addr 10 -> ReadData = 0x0000000A; a following read of addr 10 -> 0x12345678.
REQ-035 rst_n low for one edge at init count 15 -> Busy stays high for 32 cycles after release; all words read back equal to their address.
REQ-036 WriteEn with addr 31, data 0xFFFFFFFF, and ReadEn both at init cycle 2 -> ReadValid never high while Busy; after INIT, addr 31 reads 0x0000001F.
REQ-037 With DMEM_PARITY_EN, deposit a flipped bit into stored addr 5 and read it -> ParityErr = 1 together with ReadValid; without the macro, ParityErr = 0.
